// File: rtl/mix_columns_seq_if.sv
// rtl/mix_columns_seq_if.sv - state-in / state-out handshake bundle for mix_columns_seq
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport slave (
        input  in_valid,
        input  in_inv,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_inv,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential AES MixColumns/InvMixColumns engine
// Transforms COLS_PER_CYCLE columns of the held state per BUSY cycle, in place.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_seq_if.slave  io,
    output logic              busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic         mode_q, mode_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients of both matrices fit in 4 bits, so x, 2x, 4x, 8x cover every product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] coef);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{coef[0]}} & a) ^ ({8{coef[1]}} & x2) ^
               ({8{coef[2]}} & x4) ^ ({8{coef[3]}} & x8);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [3:0]  coef [4];
        logic [7:0]  b;
        logic [31:0] res;
        if (inv) coef = '{4'he, 4'hb, 4'hd, 4'h9};
        else     coef = '{4'h2, 4'h3, 4'h1, 4'h1};
        res = '0;
        for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int k = 0; k < 4; k++) begin
                b = b ^ gmul(col[31-8*k -: 8], coef[2'(k - r)]);
            end
            res[31-8*r -: 8] = b;
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        mode_d       = mode_q;
        col_cnt_d    = col_cnt_q;
        accept       = 1'b0;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        busy         = 1'b0;

        case (state_q)
            IDLE: begin
                io.in_ready = 1'b1;
                accept      = io.in_valid;
            end
            BUSY: begin
                busy = 1'b1;
                // col_cnt is always a multiple of N, so the offset picks exactly this group.
                for (int c = 0; c < 4; c++) begin
                    if (3'(2'(c) - col_cnt_q) < 3'(COLS_PER_CYCLE)) begin
                        work_d[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32], mode_q);
                    end
                end
                col_cnt_d = col_cnt_q + STEP;
                if (col_cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                io.out_valid = 1'b1;
                io.in_ready  = io.out_ready;
                if (io.out_ready) begin
                    if (io.in_valid) accept = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            work_d    = io.in_data;
            mode_d    = io.in_inv;
            col_cnt_d = 2'd0;
            state_d   = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            mode_q    <= 1'b0;
            col_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            mode_q    <= mode_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    assign io.out_data = work_q;

endmodule
